// File: rtl/cmos_init_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmos_init_pkg
// Brief    : Shared types and table-entry field layout for the CMOS sensor
//            register-initialisation sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cmos_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DELAY = 3'd5,
      ST_DONE  = 3'd6,
      ST_ERROR = 3'd7
   } state_t;

   // A table entry carrying this register address is a wait of reg_data ms
   localparam logic [15:0] DELAY_MARKER = 16'hFFFF;

   localparam int c_ENTRY_ADDR_MSB = 23;
   localparam int c_ENTRY_ADDR_LSB = 8;
   localparam int c_ENTRY_DATA_MSB = 7;
   localparam int c_ENTRY_DATA_LSB = 0;

   function automatic logic [15:0] entry_addr(input logic [23:0] entry);
      return entry[c_ENTRY_ADDR_MSB:c_ENTRY_ADDR_LSB];
   endfunction

   function automatic logic [7:0] entry_data(input logic [23:0] entry);
      return entry[c_ENTRY_DATA_MSB:c_ENTRY_DATA_LSB];
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmos_ms_timer.sv
`default_nettype none
// ============================================================================
// Module   : cmos_ms_timer
// Brief    : Free-running millisecond tick generator; one-cycle tick every
//            MS_CYCLES clocks while enabled, restarts whenever enable drops.
// Revision : 1.0 - initial release
// ============================================================================
module cmos_ms_timer #(
   parameter int MS_CYCLES = 24000
) (
   input  logic clk_24M,
   input  logic reset_n,
   input  logic i_enable,
   output logic o_tick
);

   localparam logic [14:0] c_MS_LAST = 15'(MS_CYCLES - 1);

   logic [14:0] r_ms_cnt;

   always_ff @(posedge clk_24M or negedge reset_n) begin
      if (!reset_n) begin
         r_ms_cnt <= '0;
      end else if (!i_enable || (r_ms_cnt == c_MS_LAST)) begin
         r_ms_cnt <= '0;
      end else begin
         r_ms_cnt <= r_ms_cnt + 15'd1;
      end
   end

   assign o_tick = i_enable && (r_ms_cnt == c_MS_LAST);

endmodule
`default_nettype wire

// File: rtl/cmos_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cmos_init_sequencer
// Brief    : Walks a register table, issuing one I2C write per entry with an
//            idle gap after each; 16'hFFFF entries are millisecond waits.
//            Define CMOS_INIT_RETRY_EN to re-issue NACKed entries up to
//            RETRY_MAX times before aborting.
// Revision : 1.0 - initial release
// ============================================================================
module cmos_init_sequencer
   import cmos_init_pkg::*;
#(
   parameter int REG_NUM    = 252,
   parameter int RETRY_MAX  = 3,
   parameter int GAP_CYCLES = 256,
   parameter int MS_CYCLES  = 24000
) (
   input  logic        clk_24M,
   input  logic        reset_n,
   input  logic        initial_en,
   output logic [7:0]  lut_index,
   input  logic [23:0] lut_data,
   output logic        i2c_req,
   output logic [15:0] i2c_addr,
   output logic [7:0]  i2c_wdata,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   output logic        config_done,
   output logic        config_err,
   output logic [7:0]  fail_index
);

   localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
   localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
   localparam logic [7:0]         c_LAST_IDX = 8'(REG_NUM - 1);

   state_t             r_state, w_state_next;
   logic [7:0]         r_lut_index, w_index_next;
   logic               r_i2c_req, w_req_next;
   logic [15:0]        r_i2c_addr, w_addr_next;
   logic [7:0]         r_i2c_wdata, w_wdata_next;
   logic               r_config_done, w_done_next;
   logic               r_config_err, w_err_next;
   logic [7:0]         r_fail_index, w_fail_next;
   logic [c_GAP_W-1:0] r_gap_cnt, w_gap_next;
   logic [7:0]         r_ms_left, w_ms_left_next;
   logic               w_entry_end;
   logic               w_ms_tick;

`ifdef CMOS_INIT_RETRY_EN
   localparam int                   c_RETRY_W     = ($clog2(RETRY_MAX + 1) > 2) ? $clog2(RETRY_MAX + 1) : 2;
   localparam logic [c_RETRY_W-1:0] c_RETRY_LIMIT = c_RETRY_W'(RETRY_MAX);
   localparam logic [c_RETRY_W-1:0] c_RETRY_ONE   = c_RETRY_W'(1);

   logic [c_RETRY_W-1:0] r_retry_cnt, w_retry_next;
   logic                 r_reissue, w_reissue_next;
`else
   logic [31:0] w_retry_max_unused;
   assign w_retry_max_unused = RETRY_MAX;
`endif

   cmos_ms_timer #(
      .MS_CYCLES (MS_CYCLES)
   ) u_ms_timer (
      .clk_24M  (clk_24M),
      .reset_n  (reset_n),
      .i_enable (r_state == ST_DELAY),
      .o_tick   (w_ms_tick)
   );

   always_comb begin
      w_state_next   = r_state;
      w_index_next   = r_lut_index;
      w_req_next     = r_i2c_req;
      w_addr_next    = r_i2c_addr;
      w_wdata_next   = r_i2c_wdata;
      w_done_next    = r_config_done;
      w_err_next     = r_config_err;
      w_fail_next    = r_fail_index;
      w_gap_next     = r_gap_cnt;
      w_ms_left_next = r_ms_left;
      w_entry_end    = 1'b0;
`ifdef CMOS_INIT_RETRY_EN
      w_retry_next   = r_retry_cnt;
      w_reissue_next = r_reissue;
`endif

      case (r_state)
         ST_IDLE: begin
            if (initial_en) begin
               w_state_next = ST_FETCH;
               w_index_next = 8'd0;
            end
         end
         ST_FETCH: begin
            if (entry_addr(lut_data) == DELAY_MARKER) begin
               w_ms_left_next = entry_data(lut_data);
               w_state_next   = ST_DELAY;
            end else begin
               w_addr_next  = entry_addr(lut_data);
               w_wdata_next = entry_data(lut_data);
               w_state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            w_req_next   = 1'b1;
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // A done pulse only counts while our request is actually up
            if (i2c_done && r_i2c_req) begin
               w_req_next = 1'b0;
               w_gap_next = '0;
               if (!i2c_nack) begin
                  w_state_next = ST_GAP;
`ifdef CMOS_INIT_RETRY_EN
                  w_retry_next = '0;
               end else if (r_retry_cnt < c_RETRY_LIMIT) begin
                  w_retry_next   = r_retry_cnt + c_RETRY_ONE;
                  w_reissue_next = 1'b1;
                  w_state_next   = ST_GAP;
`endif
               end else begin
                  w_err_next   = 1'b1;
                  w_fail_next  = r_lut_index;
                  w_state_next = ST_ERROR;
               end
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == c_GAP_LAST) begin
               w_gap_next = '0;
`ifdef CMOS_INIT_RETRY_EN
               if (r_reissue) begin
                  w_reissue_next = 1'b0;
                  w_state_next   = ST_FETCH;
               end else begin
                  w_entry_end = 1'b1;
               end
`else
               w_entry_end = 1'b1;
`endif
            end else begin
               w_gap_next = r_gap_cnt + c_GAP_ONE;
            end
         end
         ST_DELAY: begin
            if (r_ms_left == 8'd0) begin
               w_entry_end = 1'b1;
            end else if (w_ms_tick) begin
               w_ms_left_next = r_ms_left - 8'd1;
               w_entry_end    = (r_ms_left == 8'd1);
            end
         end
         ST_DONE,
         ST_ERROR: begin
         end
         default: w_state_next = ST_IDLE;
      endcase

      if (w_entry_end) begin
         if (r_lut_index == c_LAST_IDX) begin
            w_done_next  = 1'b1;
            w_state_next = ST_DONE;
         end else begin
            w_index_next = r_lut_index + 8'd1;
            w_state_next = ST_FETCH;
         end
      end

      // Losing initial_en abandons everything, even an in-flight write
      if (!initial_en) begin
         w_state_next   = ST_IDLE;
         w_index_next   = '0;
         w_req_next     = 1'b0;
         w_addr_next    = '0;
         w_wdata_next   = '0;
         w_done_next    = 1'b0;
         w_err_next     = 1'b0;
         w_fail_next    = '0;
         w_gap_next     = '0;
         w_ms_left_next = '0;
`ifdef CMOS_INIT_RETRY_EN
         w_retry_next   = '0;
         w_reissue_next = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_24M or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_lut_index   <= '0;
         r_i2c_req     <= 1'b0;
         r_i2c_addr    <= '0;
         r_i2c_wdata   <= '0;
         r_config_done <= 1'b0;
         r_config_err  <= 1'b0;
         r_fail_index  <= '0;
         r_gap_cnt     <= '0;
         r_ms_left     <= '0;
`ifdef CMOS_INIT_RETRY_EN
         r_retry_cnt   <= '0;
         r_reissue     <= 1'b0;
`endif
      end else begin
         r_state       <= w_state_next;
         r_lut_index   <= w_index_next;
         r_i2c_req     <= w_req_next;
         r_i2c_addr    <= w_addr_next;
         r_i2c_wdata   <= w_wdata_next;
         r_config_done <= w_done_next;
         r_config_err  <= w_err_next;
         r_fail_index  <= w_fail_next;
         r_gap_cnt     <= w_gap_next;
         r_ms_left     <= w_ms_left_next;
`ifdef CMOS_INIT_RETRY_EN
         r_retry_cnt   <= w_retry_next;
         r_reissue     <= w_reissue_next;
`endif
      end
   end

   assign lut_index   = r_lut_index;
   assign i2c_req     = r_i2c_req;
   assign i2c_addr    = r_i2c_addr;
   assign i2c_wdata   = r_i2c_wdata;
   assign config_done = r_config_done;
   assign config_err  = r_config_err;
   assign fail_index  = r_fail_index;

endmodule
`default_nettype wire

// File: tb/tb_cmos_init_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cmos_init_sequencer
// Brief    : Directed bench; instance 0 has a 3-entry table, instance 1 a
//            6-entry table, each served by a small I2C slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_init_sequencer;

   localparam int GAP_CYCLES = 256;
   localparam int MS_CYCLES  = 24000;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b1;
   logic [1:0]  initial_en = 2'b00;
   logic [1:0]  log_clr    = 2'b00;
   logic [23:0] tbl [2][8];
   logic [7:0]  nack_idx [2];
   int          nack_cnt [2];
   logic [7:0]  hold_idx [2];

   logic        i2c_req     [2];
   logic        config_done [2];
   logic        config_err  [2];
   logic [7:0]  lut_index   [2];
   logic [7:0]  fail_index  [2];
   logic [7:0]  i2c_wdata   [2];
   logic [15:0] i2c_addr    [2];

   int cyc   = 0;
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      logic        i2c_done = 1'b0;
      logic        i2c_nack = 1'b0;
      logic        prev_req = 1'b0;
      logic [23:0] lut_data;
      int          n_req     = 0;
      int          wcnt      = 0;
      int          nack_left = 0;
      logic [7:0]  ev_idx  [16];
      logic [15:0] ev_addr [16];
      logic [7:0]  ev_data [16];
      int          ev_rise [16];
      int          ev_fall [16];

      assign lut_data = tbl[k][lut_index[k][2:0]];

      cmos_init_sequencer #(
         .REG_NUM    ((k == 0) ? 3 : 6),
         .RETRY_MAX  (3),
         .GAP_CYCLES (GAP_CYCLES),
         .MS_CYCLES  (MS_CYCLES)
      ) u_dut (
         .clk_24M     (clk),
         .reset_n     (reset_n),
         .initial_en  (initial_en[k]),
         .lut_index   (lut_index[k]),
         .lut_data    (lut_data),
         .i2c_req     (i2c_req[k]),
         .i2c_addr    (i2c_addr[k]),
         .i2c_wdata   (i2c_wdata[k]),
         .i2c_done    (i2c_done),
         .i2c_nack    (i2c_nack),
         .config_done (config_done[k]),
         .config_err  (config_err[k]),
         .fail_index  (fail_index[k])
      );

      // Slave model and request logger: answers 3 cycles after req rises
      always @(negedge clk) begin
         if (log_clr[k]) begin
            n_req     = 0;
            wcnt      = 0;
            nack_left = nack_cnt[k];
            prev_req  = 1'b0;
            i2c_done  = 1'b0;
            i2c_nack  = 1'b0;
         end else begin
            if (i2c_req[k] && !prev_req) begin
               if (n_req < 16) begin
                  ev_idx[n_req]  = lut_index[k];
                  ev_addr[n_req] = i2c_addr[k];
                  ev_data[n_req] = i2c_wdata[k];
                  ev_rise[n_req] = cyc;
               end
               n_req++;
            end
            if (!i2c_req[k] && prev_req && n_req >= 1 && n_req <= 16)
               ev_fall[n_req-1] = cyc;
            prev_req = i2c_req[k];
            if (i2c_done) begin
               i2c_done = 1'b0;
               i2c_nack = 1'b0;
            end else if (i2c_req[k] && lut_index[k] != hold_idx[k]) begin
               if (wcnt == 2) begin
                  wcnt     = 0;
                  i2c_done = 1'b1;
                  i2c_nack = (lut_index[k] == nack_idx[k]) && (nack_left > 0);
                  if (i2c_nack) nack_left--;
               end else begin
                  wcnt++;
               end
            end else begin
               wcnt = 0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   function automatic int nreq(input int k);
      return (k == 0) ? g_dut[0].n_req : g_dut[1].n_req;
   endfunction

   task automatic start(input int k);
      initial_en[k] = 1'b0;
      log_clr[k]    = 1'b1;
      tick(2);
      log_clr[k]    = 1'b0;
      initial_en[k] = 1'b1;
   endtask

   task automatic wait_end(input int k, input int budget, input string tag, output int at);
      int n = 0;
      while (!(config_done[k] || config_err[k]) && n < budget) begin
         tick(1);
         n++;
      end
      at = cyc;
      check({tag, "_finished"}, (n < budget), 1);
   endtask

   task automatic wait_req(input int k, input int budget, input string tag);
      int n = 0;
      while (!i2c_req[k] && n < budget) begin
         tick(1);
         n++;
      end
      check({tag, "_req_seen"}, (n < budget), 1);
   endtask

   logic [15:0] t1_addr [3] = '{16'h3008, 16'h3103, 16'h3017};
   logic [7:0]  t1_data [3] = '{8'h82, 8'h03, 8'hFF};

   initial begin
      int at;
      int d;
      int n;
      int exp_n;
      for (int k = 0; k < 2; k++) begin
         nack_idx[k] = 8'hFF;
         nack_cnt[k] = 0;
         hold_idx[k] = 8'hFF;
         for (int i = 0; i < 8; i++)
            tbl[k][i] = {16'(16'h3000 + i), 8'(8'h10 + i)};
      end
      for (int i = 0; i < 3; i++) tbl[0][i] = {t1_addr[i], t1_data[i]};

      // Reset state
      #2 reset_n = 1'b0;
      tick(3);
      check("rst_lut_index", lut_index[1], 0);
      check("rst_i2c_req", i2c_req[1], 0);
      check("rst_i2c_addr", i2c_addr[1], 0);
      check("rst_i2c_wdata", i2c_wdata[1], 0);
      check("rst_config_done", config_done[1], 0);
      check("rst_config_err", config_err[1], 0);
      check("rst_fail_index", fail_index[1], 0);
      reset_n = 1'b1;
      tick(2);

      // Test 1: three-entry table, all ACK
      start(0);
      wait_end(0, 3000, "t1", at);
      check("t1_done", config_done[0], 1);
      check("t1_err", config_err[0], 0);
      check("t1_nreq", nreq(0), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t1_idx%0d", i), g_dut[0].ev_idx[i], i);
         check($sformatf("t1_addr%0d", i), g_dut[0].ev_addr[i], t1_addr[i]);
         check($sformatf("t1_data%0d", i), g_dut[0].ev_data[i], t1_data[i]);
      end
      for (int i = 0; i < 2; i++)
         check($sformatf("t1_gap%0d", i), g_dut[0].ev_rise[i+1] - g_dut[0].ev_fall[i], GAP_CYCLES + 2);
      check("t1_gap_to_done", at - g_dut[0].ev_fall[2], GAP_CYCLES);
      tick(5);
      check("t1_done_sticky", config_done[0], 1);

      // Test 2: entry 1 is a 2 ms wait
      tbl[1][1] = {16'hFFFF, 8'd2};
      start(1);
      wait_end(1, 60000, "t2", at);
      check("t2_done", config_done[1], 1);
      check("t2_nreq", nreq(1), 5);
      check("t2_next_idx", g_dut[1].ev_idx[1], 2);
      check("t2_next_addr", g_dut[1].ev_addr[1], 16'h3002);
      check("t2_next_data", g_dut[1].ev_data[1], 8'h12);
      d = g_dut[1].ev_rise[1] - g_dut[1].ev_fall[0] - (GAP_CYCLES + 3);
      n_chk++;
      assert (d >= 2 * MS_CYCLES - 1 && d <= 2 * MS_CYCLES + 1) else begin
         n_err++;
         $error("FAIL t2_delay_len: observed=%0d expected=%0d+-1", d, 2 * MS_CYCLES);
      end
      tbl[1][1] = {16'h3001, 8'h11};

      // Test 3: entry 0 NACKs twice
      nack_idx[1] = 8'd0;
      nack_cnt[1] = 2;
      start(1);
      wait_end(1, 5000, "t3", at);
`ifdef CMOS_INIT_RETRY_EN
      check("t3_done", config_done[1], 1);
      check("t3_err", config_err[1], 0);
      check("t3_nreq", nreq(1), 8);
      for (int i = 0; i < 3; i++)
         check($sformatf("t3_retry_idx%0d", i), g_dut[1].ev_idx[i], 0);
      check("t3_after_retry_idx", g_dut[1].ev_idx[3], 1);
      check("t3_retry_gap", g_dut[1].ev_rise[1] - g_dut[1].ev_fall[0], GAP_CYCLES + 2);
`else
      check("t3_err", config_err[1], 1);
      check("t3_done", config_done[1], 0);
      check("t3_nreq", nreq(1), 1);
      check("t3_fail_index", fail_index[1], 0);
`endif

      // Test 4: entry 5 always NACKs
      nack_idx[1] = 8'd5;
      nack_cnt[1] = 255;
      start(1);
      wait_end(1, 5000, "t4", at);
`ifdef CMOS_INIT_RETRY_EN
      exp_n = 9;
`else
      exp_n = 6;
`endif
      n = nreq(1);
      check("t4_nreq", n, exp_n);
      check("t4_err", config_err[1], 1);
      check("t4_done", config_done[1], 0);
      check("t4_fail_index", fail_index[1], 5);
      check("t4_last_idx", g_dut[1].ev_idx[exp_n-1], 5);
      tick(5);
      check("t4_err_sticky", config_err[1], 1);
      nack_idx[1] = 8'hFF;
      nack_cnt[1] = 0;

      // Test 5: initial_en dropped while waiting on entry 2
      hold_idx[1] = 8'd2;
      start(1);
      n = 0;
      while (!(i2c_req[1] && nreq(1) == 3) && n < 3000) begin
         tick(1);
         n++;
      end
      check("t5_reach_wait", (n < 3000), 1);
      tick(3);
      check("t5_req_held", i2c_req[1], 1);
      check("t5_idx_held", lut_index[1], 2);
      initial_en[1] = 1'b0;
      tick(1);
      check("t5_req_drop", i2c_req[1], 0);
      check("t5_idx_clear", lut_index[1], 0);
      check("t5_addr_clear", i2c_addr[1], 0);
      hold_idx[1] = 8'hFF;
      start(1);
      wait_req(1, 20, "t5_restart");
      check("t5_restart_idx", lut_index[1], 0);
      check("t5_restart_ev_idx", g_dut[1].ev_idx[0], 0);
      wait_end(1, 3000, "t5", at);
      check("t5_done", config_done[1], 1);

      // Test 6: asynchronous reset in the middle of a wait
      tbl[1][1] = {16'hFFFF, 8'd2};
      start(1);
      n = 0;
      while (lut_index[1] != 8'd1 && n < 2000) begin
         tick(1);
         n++;
      end
      check("t6_reach_delay", (n < 2000), 1);
      tick(100);
      check("t6_pre_idx", lut_index[1], 1);
      check("t6_pre_addr", i2c_addr[1], 16'h3000);
      check("t6_pre_req", i2c_req[1], 0);
      #1 reset_n = 1'b0;
      #1;
      check("t6_rst_idx", lut_index[1], 0);
      check("t6_rst_addr", i2c_addr[1], 0);
      check("t6_rst_wdata", i2c_wdata[1], 0);
      check("t6_rst_done", config_done[1], 0);
      check("t6_rst_err", config_err[1], 0);
      initial_en[1] = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(3);
      check("t6_idle_idx", lut_index[1], 0);
      check("t6_idle_req", i2c_req[1], 0);
      start(1);
      wait_req(1, 20, "t6_restart");
      check("t6_restart_idx", lut_index[1], 0);
      check("t6_restart_addr", i2c_addr[1], 16'h3000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
